i2c_passthru_bittx: RTL

I2C_PASSTHRU_BITTX -- requirements
Module: i2c_passthru_bittx

---
 rtl/i2c_passthru_bittx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_passthru_bittx.sv
// Single-bit I2C transmitter: drives one data bit, start or stop with tick-timed SCL phases.
// Optional SDA arbitration check enabled by defining I2C_PASSTHRU_BITTX_ARB_EN.
module i2c_passthru_bittx #(
    parameter int unsigned F_REF_T_LOW       = 38,
    parameter int unsigned WIDTH_F_REF_T_LOW = 6
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_f_ref,
    input  logic       i_start_tx,
    input  logic [1:0] i_tx_type,
    input  logic       i_tx_bit,
    input  logic       i_rx_done,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl,
    output logic       o_sda,
    output logic       o_tx_done,
    output logic       o_violation
);

    localparam int unsigned   TW      = WIDTH_F_REF_T_LOW;
    localparam logic [TW-1:0] T_LOAD  = TW'(F_REF_T_LOW);
    localparam logic [1:0]    TX_DATA  = 2'b00;
    localparam logic [1:0]    TX_START = 2'b01;
    localparam logic [1:0]    TX_STOP  = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SCL0      = 4'd1,
        ST_SCL1_WAIT = 4'd2,
        ST_SCL1_HOLD = 4'd3,
        ST_STA_HOLD  = 4'd4,
        ST_STO_BUF   = 4'd5,
        ST_DONE_LOW  = 4'd6,
        ST_DONE      = 4'd7,
        ST_VIOLATION = 4'd8
    } state_t;

    state_t        state_q, state_nxt;
    logic [1:0]    type_q, type_nxt;
    logic          bit_q, bit_nxt;
    logic          park_q, park_nxt;
    logic          scl_nxt, sda_nxt, done_nxt, viol_nxt;
    logic          phase_sda;
    logic [TW-1:0] cnt_q;
    logic          f_ref_q;
    logic          tick;
    logic          tc;
    logic          timer_clr;
    logic          arb_lost;

`ifdef I2C_PASSTHRU_BITTX_ARB_EN
    assign arb_lost = (i_sda != o_sda);
`else
    logic unused_sda;
    assign unused_sda = i_sda;
    assign arb_lost   = 1'b0;
`endif

    assign tick = i_f_ref & ~f_ref_q;
    assign tc   = (cnt_q == '0);

    // Tick down-counter; reloads whenever the FSM clears it, saturates at zero.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            f_ref_q <= 1'b1;
            cnt_q   <= T_LOAD;
        end else begin
            f_ref_q <= i_f_ref;
            if (timer_clr) begin
                cnt_q <= T_LOAD;
            end else if (tick && !tc) begin
                cnt_q <= cnt_q - TW'(1);
            end
        end
    end

    // State, captured request and registered bus outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            type_q      <= TX_DATA;
            bit_q       <= 1'b1;
            park_q      <= 1'b1;
            o_scl       <= 1'b1;
            o_sda       <= 1'b1;
            o_tx_done   <= 1'b1;
            o_violation <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            type_q      <= type_nxt;
            bit_q       <= bit_nxt;
            park_q      <= park_nxt;
            o_scl       <= scl_nxt;
            o_sda       <= sda_nxt;
            o_tx_done   <= done_nxt;
            o_violation <= viol_nxt;
        end
    end

    // Next state, then the outputs of that next state so they line up with it.
    always_comb begin
        state_nxt = state_q;
        type_nxt  = type_q;
        bit_nxt   = bit_q;
        park_nxt  = park_q;
        timer_clr = 1'b0;
        scl_nxt   = 1'b1;
        sda_nxt   = 1'b1;
        done_nxt  = 1'b0;
        viol_nxt  = 1'b0;
        phase_sda = 1'b1;

        case (state_q)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (i_start_tx) begin
                    type_nxt = i_tx_type;
                    bit_nxt  = i_tx_bit;
                    case (i_tx_type)
                        TX_DATA, TX_STOP: state_nxt = ST_SCL0;
                        TX_START:         state_nxt = park_q ? ST_STA_HOLD : ST_SCL0;
                        default:          state_nxt = ST_VIOLATION;
                    endcase
                end
            end
            ST_SCL0: begin
                if (tc) state_nxt = ST_SCL1_WAIT;
            end
            ST_SCL1_WAIT: begin
                timer_clr = 1'b1;
                if (i_scl) state_nxt = ST_SCL1_HOLD;
            end
            ST_SCL1_HOLD: begin
                if (arb_lost) begin
                    state_nxt = ST_VIOLATION;
                end else if (tc) begin
                    case (type_q)
                        TX_DATA:  state_nxt = ST_DONE_LOW;
                        TX_START: state_nxt = ST_STA_HOLD;
                        TX_STOP:  state_nxt = ST_STO_BUF;
                        default:  state_nxt = ST_VIOLATION;
                    endcase
                end else if (!i_scl) begin
                    state_nxt = ST_VIOLATION;
                end
            end
            ST_STA_HOLD: begin
                if (arb_lost)  state_nxt = ST_VIOLATION;
                else if (tc)   state_nxt = ST_DONE_LOW;
            end
            ST_STO_BUF: begin
                if (tc) begin
                    park_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE_LOW: begin
                park_nxt  = 1'b0;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (i_rx_done) state_nxt = ST_IDLE;
            end
            ST_VIOLATION: state_nxt = ST_VIOLATION;
            default:      state_nxt = ST_IDLE;
        endcase

        if (state_nxt != state_q) timer_clr = 1'b1;

        if (type_nxt == TX_DATA) phase_sda = bit_nxt;
        else                     phase_sda = (type_nxt == TX_START);

        case (state_nxt)
            ST_IDLE: begin
                scl_nxt  = park_nxt;
                sda_nxt  = o_sda;
                done_nxt = 1'b1;
            end
            ST_SCL0: begin
                scl_nxt = 1'b0;
                sda_nxt = phase_sda;
            end
            ST_SCL1_WAIT, ST_SCL1_HOLD: sda_nxt = phase_sda;
            ST_STA_HOLD:                sda_nxt = 1'b0;
            ST_STO_BUF:                 sda_nxt = 1'b1;
            ST_DONE_LOW: begin
                scl_nxt = 1'b0;
                sda_nxt = o_sda;
            end
            ST_DONE: begin
                scl_nxt  = park_nxt;
                sda_nxt  = o_sda;
                done_nxt = 1'b1;
            end
            ST_VIOLATION: viol_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule
